// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter for the picorv32 native memory port: registered request/response, one
// outstanding transaction, round-robin grant (fixed priority with PICORV32_MEM_ARBITER_FIXED_PRIO_EN).
module picorv32_mem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_MASTERS-1:0]        m_mem_valid,
   input  logic [NUM_MASTERS-1:0]        m_mem_instr,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_mem_addr,
   input  logic [NUM_MASTERS*32-1:0]     m_mem_wdata,
   input  logic [NUM_MASTERS*4-1:0]      m_mem_wstrb,
   output logic [NUM_MASTERS-1:0]        m_mem_ready,
   output logic [31:0]                   m_mem_rdata,
   output logic                          s_mem_valid,
   output logic                          s_mem_instr,
   output logic [ADDR_W-1:0]             s_mem_addr,
   output logic [31:0]                   s_mem_wdata,
   output logic [3:0]                    s_mem_wstrb,
   input  logic                          s_mem_ready,
   input  logic [31:0]                   s_mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t              state;
   logic                grant;
   logic                last_grant;
   logic                winner;
   logic                win_instr;
   logic [ADDR_W-1:0]   win_addr;
   logic [31:0]         win_wdata;
   logic [3:0]          win_wstrb;

   always_comb begin
      winner = 1'b0;
      if (m_mem_valid[0] && m_mem_valid[1]) begin
`ifdef PICORV32_MEM_ARBITER_FIXED_PRIO_EN
         winner = 1'b0;
`else
         winner = ~last_grant;
`endif
      end else if (m_mem_valid[1]) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      win_instr = winner ? m_mem_instr[1] : m_mem_instr[0];
      win_addr  = winner ? m_mem_addr[2*ADDR_W-1:ADDR_W] : m_mem_addr[ADDR_W-1:0];
      win_wdata = winner ? m_mem_wdata[63:32] : m_mem_wdata[31:0];
      win_wstrb = winner ? m_mem_wstrb[7:4] : m_mem_wstrb[3:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         m_mem_ready <= '0;
         m_mem_rdata <= '0;
         s_mem_valid <= 1'b0;
         s_mem_instr <= 1'b0;
         s_mem_addr  <= '0;
         s_mem_wdata <= '0;
         s_mem_wstrb <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|m_mem_valid) begin
                  grant       <= winner;
                  last_grant  <= winner;
                  s_mem_instr <= win_instr;
                  s_mem_addr  <= win_addr;
                  s_mem_wdata <= win_wdata;
                  s_mem_wstrb <= win_wstrb;
                  s_mem_valid <= 1'b1;
                  state       <= REQ;
               end
            end
            // Request is frozen until the slave answers; requester valid is not looked at here.
            REQ: begin
               if (s_mem_ready) begin
                  s_mem_valid <= 1'b0;
                  m_mem_ready <= grant ? 2'b10 : 2'b01;
                  m_mem_rdata <= s_mem_rdata;
                  state       <= RESP;
               end
            end
            RESP: begin
               m_mem_ready <= '0;
               state       <= IDLE;
            end
            default: begin
               s_mem_valid <= 1'b0;
               m_mem_ready <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Table-driven bench for picorv32_mem_arbiter with a scoreboard of expected completions.
module tb_picorv32_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  m_mem_valid;
   logic [1:0]  m_mem_instr;
   logic [63:0] m_mem_addr;
   logic [63:0] m_mem_wdata;
   logic [7:0]  m_mem_wstrb;
   logic [1:0]  m_mem_ready;
   logic [31:0] m_mem_rdata;
   logic        s_mem_valid;
   logic        s_mem_instr;
   logic [31:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [3:0]  s_mem_wstrb;
   logic        s_mem_ready;
   logic [31:0] s_mem_rdata;

   picorv32_mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .m_mem_valid(m_mem_valid), .m_mem_instr(m_mem_instr), .m_mem_addr(m_mem_addr),
      .m_mem_wdata(m_mem_wdata), .m_mem_wstrb(m_mem_wstrb),
      .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
      .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
      .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
      .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          wait_n;
      logic [31:0] rdata;
      logic        raise;
   } vec_t;

   typedef struct {
      logic        m;
      logic [31:0] rdata;
      logic [31:0] addr;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input vec_t v);
      m_mem_valid[v.m] = 1'b1;
      m_mem_instr[v.m] = v.instr;
      if (v.m) begin
         m_mem_addr[63:32]  = v.addr;
         m_mem_wdata[63:32] = v.wdata;
         m_mem_wstrb[7:4]   = v.wstrb;
      end else begin
         m_mem_addr[31:0]  = v.addr;
         m_mem_wdata[31:0] = v.wdata;
         m_mem_wstrb[3:0]  = v.wstrb;
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      e = '{1'b0, 32'h0, 32'h0};
      if (sb.size() == 0) begin
         nvec++;
         nerr++;
         $display("FAIL %s_sb: completion with empty scoreboard, got ready %b", tag, m_mem_ready);
      end else begin
         e = sb.pop_front();
         chk({tag, "_ready"}, 64'(m_mem_ready), e.m ? 64'h2 : 64'h1);
         chk({tag, "_rdata"}, 64'(m_mem_rdata), 64'(e.rdata));
         chk({tag, "_addr"}, 64'(s_mem_addr), 64'(e.addr));
      end
   endtask

   // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
   task automatic run_vec(input vec_t v, input vec_t other);
      drive_req(v);
      sb.push_back('{v.m, v.rdata, v.addr});
      @(negedge clk);
      chk("s_valid", 64'(s_mem_valid), 64'h1);
      chk("s_addr", 64'(s_mem_addr), 64'(v.addr));
      chk("s_instr", 64'(s_mem_instr), 64'(v.instr));
      chk("s_wdata", 64'(s_mem_wdata), 64'(v.wdata));
      chk("s_wstrb", 64'(s_mem_wstrb), 64'(v.wstrb));
      for (int i = 0; i < v.wait_n; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(s_mem_valid), 64'h1);
         chk("hold_addr", 64'(s_mem_addr), 64'(v.addr));
         chk("hold_ready", 64'(m_mem_ready), 64'h0);
         if (v.raise && i == 2) drive_req(other);
      end
      s_mem_ready = 1'b1;
      s_mem_rdata = v.rdata;
      @(negedge clk);
      pop_check("done");
      chk("resp_svalid", 64'(s_mem_valid), 64'h0);
      s_mem_ready = 1'b0;
      s_mem_rdata = 32'hA5A5_A5A5;
      m_mem_valid[v.m] = 1'b0;
      @(negedge clk);
      chk("ready_clr", 64'(m_mem_ready), 64'h0);
   endtask

   initial begin
      int   seen;
      int   last_c;
      int   cnt0;
      int   cnt1;
      vec_t va;
      vec_t vb;

      vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h1000_0000, 32'h41, 4'b0001, 5, 32'h0000_0000, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'hF, 0, 32'hCAFE_F00D, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 10, 32'h1111_2222, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0400, 32'h0, 4'h0, 0, 32'h3333_4444, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0600, 32'h9, 4'hC, 2, 32'h5566_7788, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0700, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0};

      resetn = 1'b0;
      m_mem_valid = '0;
      m_mem_instr = '0;
      m_mem_addr = '0;
      m_mem_wdata = '0;
      m_mem_wstrb = '0;
      s_mem_ready = 1'b0;
      s_mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_svalid", 64'(s_mem_valid), 64'h0);
      chk("rst_mready", 64'(m_mem_ready), 64'h0);
      chk("rst_rdata", 64'(m_mem_rdata), 64'h0);
      chk("rst_saddr", 64'(s_mem_addr), 64'h0);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], vecs[(i + 1) % 7]);
      end

      // Reset while a request is outstanding downstream.
      va = '{1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 32'h0, 1'b0};
      drive_req(va);
      @(negedge clk);
      chk("mid_svalid_pre", 64'(s_mem_valid), 64'h1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_svalid", 64'(s_mem_valid), 64'h0);
      chk("mid_mready", 64'(m_mem_ready), 64'h0);
      chk("mid_rdata", 64'(m_mem_rdata), 64'h0);
      m_mem_valid = '0;
      @(negedge clk);
      resetn = 1'b1;
      run_vec(vecs[5], vecs[5]);

      // Stray slave completion while idle.
      s_mem_ready = 1'b1;
      s_mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stray_mready", 64'(m_mem_ready), 64'h0);
      chk("stray_svalid", 64'(s_mem_valid), 64'h0);
      chk("stray_rdata", 64'(m_mem_rdata), 64'(vecs[5].rdata));
      s_mem_ready = 1'b0;
      @(negedge clk);
      chk("stray_mready2", 64'(m_mem_ready), 64'h0);
      run_vec(vecs[6], vecs[6]);

      // Both masters hold requests against a zero-wait slave, starting from reset.
      resetn = 1'b0;
      @(negedge clk);
      chk("rst2_svalid", 64'(s_mem_valid), 64'h0);
      resetn = 1'b1;
      va = '{1'b0, 1'b0, 32'h0000_00A0, 32'h0, 4'h0, 0, 32'h0, 1'b0};
      vb = '{1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'h0, 0, 32'h0, 1'b0};
      drive_req(va);
      drive_req(vb);
      for (int k = 0; k < 8; k++) begin
`ifdef PICORV32_MEM_ARBITER_FIXED_PRIO_EN
         sb.push_back(k < 4 ? '{1'b0, 32'h100 + k, 32'hA0} : '{1'b1, 32'h100 + k, 32'hB0});
`else
         sb.push_back((k % 2) == 0 ? '{1'b0, 32'h100 + k, 32'hA0} : '{1'b1, 32'h100 + k, 32'hB0});
`endif
      end
      seen = 0;
      last_c = 0;
      cnt0 = 0;
      cnt1 = 0;
      for (int c = 0; c < 60 && seen < 8; c++) begin
         @(negedge clk);
         if (m_mem_ready != 2'b00) begin
            pop_check("rr");
            if (seen > 0) chk("rr_spacing", 64'(c - last_c), 64'd3);
            last_c = c;
            seen++;
            if (m_mem_ready[0]) cnt0++;
            if (m_mem_ready[1]) cnt1++;
            if (cnt0 == 4) m_mem_valid[0] = 1'b0;
            if (cnt1 == 4) m_mem_valid[1] = 1'b0;
         end
         s_mem_ready = s_mem_valid;
         s_mem_rdata = 32'h100 + seen;
      end
      chk("rr_count", 64'(seen), 64'd8);
      s_mem_ready = 1'b0;
      m_mem_valid = '0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
